// File: rtl/display_sched_pkg.sv
// Shared register map, control-word bit positions and display-mode encoding
// for the display frame scheduler.
package display_sched_pkg;

   localparam logic [2:0] ADDR_PIPE1      = 3'd0;
   localparam logic [2:0] ADDR_PIPE2      = 3'd1;
   localparam logic [2:0] ADDR_PIPE3      = 3'd2;
   localparam logic [2:0] ADDR_PIPE4      = 3'd3;
   localparam logic [2:0] ADDR_BIRD       = 3'd4;
   localparam logic [2:0] ADDR_CUR_SCORE  = 3'd5;
   localparam logic [2:0] ADDR_HIGH_SCORE = 3'd6;
   localparam logic [2:0] ADDR_CTRL       = 3'd7;

   localparam int unsigned NUM_DISP_REGS = 7;
   // Pipes, bird and current score: the registers wiped when a game ends.
   localparam int unsigned NUM_GAME_REGS = 6;

   localparam int unsigned CTRL_COMMIT_BIT    = 0;
   localparam int unsigned CTRL_GAME_OVER_BIT = 1;

   typedef enum logic [1:0] {
      MODE_SPLASH = 2'd0,
      MODE_PLAY   = 2'd1,
      MODE_OVER   = 2'd2
   } mode_e;

endpackage

// File: rtl/display_frame_scheduler_frame_timer.sv
// Frame counter advanced by screenEnd ticks, with synchronous clear.
// WRAP=0 saturates at TERMINAL; WRAP=1 counts modulo TERMINAL and flags each wrap.
module frame_timer #(
   parameter int unsigned TERMINAL = 30,
   parameter bit          WRAP     = 1'b0,
   localparam int unsigned W       = $clog2(TERMINAL + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         tick_i,
   output logic [W-1:0] count_o,
   output logic         tc_o
);

   localparam logic [W-1:0] TERM_C = W'(TERMINAL);
   localparam logic [W-1:0] LAST_C = WRAP ? W'(TERMINAL - 1) : W'(TERMINAL);

   logic [W-1:0] count_q, count_d;
   logic         at_last;

   assign at_last = (count_q == LAST_C);

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (tick_i) begin
         if (!at_last) begin
            count_d = count_q + 1'b1;
         end else if (WRAP) begin
            count_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   // Wrap mode: pulse on the tick that wraps. Saturate mode: level once at terminal.
   assign tc_o    = WRAP ? (tick_i && at_last) : (count_q >= TERM_C);

endmodule

// File: rtl/display_frame_scheduler.sv
// Double-buffers processor writes to the display registers, commits them at the
// frame boundary, and sequences splash / play / game-over modes with overlay blink.
module display_frame_scheduler
   import display_sched_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES        = 30,
   parameter int unsigned OVER_MIN_FRAMES     = 60,
   parameter int unsigned OVER_TIMEOUT_FRAMES = 600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        screenEnd,
   input  logic        jump,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [31:0] wr_data,
   output logic        commit_pending,
   output logic        frame_ack,
   output logic [31:0] pipe1_out,
   output logic [31:0] pipe2_out,
   output logic [31:0] pipe3_out,
   output logic [31:0] pipe4_out,
   output logic [31:0] bird_out,
   output logic [31:0] cur_score_out,
   output logic [31:0] high_score_out,
   output logic [1:0]  mode,
   output logic        blink,
   output logic [15:0] frame_count
);

   localparam int unsigned OW = $clog2(OVER_TIMEOUT_FRAMES + 1);
   localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [OW-1:0] OVER_MIN_C = OW'(OVER_MIN_FRAMES);

   logic [31:0] pend_q   [NUM_DISP_REGS];
   logic [31:0] pend_d   [NUM_DISP_REGS];
   logic [31:0] shadow_q [NUM_DISP_REGS];
   logic [31:0] shadow_d [NUM_DISP_REGS];

   logic        commit_pending_q, commit_pending_d;
   logic        frame_ack_q;
   logic        blink_q, blink_d;
   logic [15:0] frame_count_q, frame_count_d;
   mode_e       mode_q, mode_d;

   logic          ctrl_wr, commit_req, game_over_req, commit_edge;
   logic          game_nonzero, leave_over, blink_clr, blink_wrap;
   logic [OW-1:0] over_cnt;
   logic          over_timeout;
   logic [BW-1:0] unused_blink_cnt;

   assign ctrl_wr       = wr_en && (wr_addr == ADDR_CTRL);
   assign commit_req    = ctrl_wr && wr_data[CTRL_COMMIT_BIT];
   assign game_over_req = ctrl_wr && wr_data[CTRL_GAME_OVER_BIT];
   assign commit_edge   = screenEnd && commit_pending_q;

   assign leave_over = (mode_q == MODE_OVER) &&
                       (((over_cnt >= OVER_MIN_C) && jump) || over_timeout);

   always_comb begin
      game_nonzero = 1'b0;
      for (int unsigned i = 0; i < NUM_GAME_REGS; i++) begin
         game_nonzero = game_nonzero | (pend_q[i] != '0);
      end
   end

   always_comb begin
      mode_d = mode_q;
      unique case (mode_q)
         MODE_SPLASH: if (commit_edge && game_nonzero) mode_d = MODE_PLAY;
         MODE_PLAY:   if (game_over_req)               mode_d = MODE_OVER;
         MODE_OVER:   if (leave_over)                  mode_d = MODE_SPLASH;
         default:                                      mode_d = MODE_SPLASH;
      endcase
   end

   // Shadow copies the pre-write pending values; a write on the commit edge stays pending.
   always_comb begin
      pend_d           = pend_q;
      shadow_d         = shadow_q;
      commit_pending_d = (commit_pending_q && !commit_edge) || commit_req;
      frame_count_d    = screenEnd ? frame_count_q + 16'd1 : frame_count_q;

      if (commit_edge) begin
         shadow_d = pend_q;
      end
      if (wr_en && (wr_addr != ADDR_CTRL)) begin
         pend_d[wr_addr] = wr_data;
      end
      if (leave_over) begin
         for (int unsigned i = 0; i < NUM_GAME_REGS; i++) begin
            pend_d[i]   = '0;
            shadow_d[i] = '0;
         end
         commit_pending_d = 1'b0;
      end
   end

   assign blink_clr = (mode_d != mode_q) || (mode_q == MODE_PLAY);

   always_comb begin
      blink_d = blink_q;
      if (blink_clr) begin
         blink_d = 1'b0;
      end else if (blink_wrap) begin
         blink_d = ~blink_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q           <= '{default: '0};
         shadow_q         <= '{default: '0};
         commit_pending_q <= 1'b0;
         frame_ack_q      <= 1'b0;
         blink_q          <= 1'b0;
         frame_count_q    <= '0;
         mode_q           <= MODE_SPLASH;
      end else begin
         pend_q           <= pend_d;
         shadow_q         <= shadow_d;
         commit_pending_q <= commit_pending_d;
         frame_ack_q      <= commit_edge;
         blink_q          <= blink_d;
         frame_count_q    <= frame_count_d;
         mode_q           <= mode_d;
      end
   end

   // Held at zero outside OVER, so it reads zero on the entry edge.
   frame_timer #(
      .TERMINAL (OVER_TIMEOUT_FRAMES),
      .WRAP     (1'b0)
   ) u_over_timer (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (mode_q != MODE_OVER),
      .tick_i  (screenEnd),
      .count_o (over_cnt),
      .tc_o    (over_timeout)
   );

   frame_timer #(
      .TERMINAL (BLINK_FRAMES),
      .WRAP     (1'b1)
   ) u_blink_timer (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (blink_clr),
      .tick_i  (screenEnd),
      .count_o (unused_blink_cnt),
      .tc_o    (blink_wrap)
   );

   assign commit_pending = commit_pending_q;
   assign frame_ack      = frame_ack_q;
   assign pipe1_out      = shadow_q[ADDR_PIPE1];
   assign pipe2_out      = shadow_q[ADDR_PIPE2];
   assign pipe3_out      = shadow_q[ADDR_PIPE3];
   assign pipe4_out      = shadow_q[ADDR_PIPE4];
   assign bird_out       = shadow_q[ADDR_BIRD];
   assign cur_score_out  = shadow_q[ADDR_CUR_SCORE];
   assign high_score_out = shadow_q[ADDR_HIGH_SCORE];
   assign mode           = mode_q;
   assign blink          = blink_q;
   assign frame_count    = frame_count_q;

endmodule

// File: doc/display_frame_scheduler.md
Name: display_frame_scheduler

Overview:
- Sits between the processor's memory-mapped game registers and the VGA display datapath.
- Buffers processor writes to the seven display registers (pipe1..4, bird, current score, high score) and commits them atomically at the frame boundary (screenEnd), so no frame shows a half-updated scene.
- Sequences the display mode (splash / play / game-over) and generates a frame-rate blink for overlays.

Parameters:
- BLINK_FRAMES, 30: frames per blink half-period in SPLASH/OVER.
- OVER_MIN_FRAMES, 60: frames OVER must be held before jump can return to SPLASH.
- OVER_TIMEOUT_FRAMES, 600: frames after which OVER returns to SPLASH on its own.

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-high reset
- screenEnd  in  1  one-cycle pulse between frames (clk domain)
- jump  in  1  level, player input
- wr_en  in  1  write strobe, single cycle
- wr_addr  in  3  0-3 pipe1..4, 4 bird, 5 current_score, 6 high_score, 7 control
- wr_data  in  32  write data; at addr 7, bit0 = commit request, bit1 = game_over
- commit_pending  out  1  commit requested, not yet applied
- frame_ack  out  1  one-cycle pulse in the cycle shadow registers update
- pipe1_out..pipe4_out, bird_out, cur_score_out, high_score_out  out  32 each  shadow registers feeding the display
- mode  out  2  0 SPLASH, 1 PLAY, 2 OVER (3 unused)
- blink  out  1  overlay blink
- frame_count  out  16  free-running frame counter

Behaviour:
- Reset state: all pending and shadow registers 0, commit_pending 0, frame_ack 0, mode SPLASH, blink 0, frame_count 0, internal frame timers 0.
- Reset asserted mid-frame or mid-commit clears everything on that edge, including an outstanding commit.
- Pending write: wr_en with addr 0-6 loads pending[addr] on that edge. Writes are never stalled.
- Control write: wr_en with addr 7 sets commit_pending if bit0 = 1, and raises game_over if bit1 = 1. Bits 31:2 are ignored.
- Commit: on an edge where screenEnd=1 and commit_pending=1:
  - every shadow register loads its pending value;
  - commit_pending clears;
  - frame_ack is 1 for the following cycle only.
- Latency from screenEnd to new shadow values is 1 clk.
- Simultaneous events:
  - A pending write in the same cycle as a commit edge: the shadow takes the pre-write value; the new value stays pending.
  - A commit request in the same cycle as screenEnd is deferred to the next screenEnd.
  - A second commit request while pending has no extra effect.
- Without commit_pending, screenEnd leaves the shadow registers unchanged.
- frame_count increments on every screenEnd and wraps 0xFFFF -> 0.
- Mode FSM, evaluated on edges:
  - SPLASH -> PLAY at the commit edge if any committed value (pipe1..4, bird, current score) is nonzero.
  - PLAY -> OVER on a game_over control write. The write is also accepted in SPLASH, where it is ignored.
  - OVER -> SPLASH when the OVER frame timer is >= OVER_MIN_FRAMES and jump = 1, or when the timer reaches OVER_TIMEOUT_FRAMES.
  - Entering SPLASH from OVER zeroes the pending and shadow copies of pipe1..4, bird and current score, keeps high_score, and clears commit_pending.
- OVER frame timer: clears on entry to OVER and counts screenEnd pulses while in OVER. It saturates; it does not wrap.
- Blink:
  - In SPLASH/OVER, a frame counter toggles blink every BLINK_FRAMES screenEnds.
  - In PLAY, blink = 0 and the counter is held at 0.
  - Every mode change zeroes the counter and sets blink = 0.
- Arithmetic: all counters are unsigned with comparisons at full width. Counter widths are $clog2(parameter+1).

Decomposition:
- Package display_sched_pkg holds:
  - address localparams ADDR_PIPE1..ADDR_HIGH_SCORE and ADDR_CTRL;
  - the control bit indices;
  - the mode encodings MODE_SPLASH / MODE_PLAY / MODE_OVER.
- One sub-module, frame_timer: a screenEnd-driven counter with clear, saturate and terminal-count flag. It is instantiated for both the blink timer and the OVER timer.

Test Plan:
- Reset, then write pipe1=0x0001_0040 with no commit, then screenEnd -> pipe1_out stays 0, frame_count=1, mode SPLASH.
- Write bird=0x0000_00C8, then ctrl=0x1, then screenEnd -> the next cycle has bird_out=0xC8, pipe1_out=0x0001_0040, frame_ack high for 1 cycle, commit_pending=0, mode PLAY.
- With a commit pending, write pipe2=5 in the same cycle as screenEnd -> pipe2_out keeps its old value; the next commit plus screenEnd gives pipe2_out=5.
- In PLAY, write ctrl=0x2, then jump=1 at frame 10 -> mode stays OVER. With jump=1 after 60 frames -> mode SPLASH, pipe/bird/current-score outputs 0, high_score_out unchanged.
- In OVER with jump=0, run 600 screenEnds -> mode returns to SPLASH. In SPLASH, blink toggles every 30 screenEnds.
- Assert reset during PLAY with a commit pending -> the next cycle has all outputs 0, mode SPLASH, and no frame_ack at the following screenEnd.
